// File: rtl/pipe_scroller.sv
// pipe_scroller
//   Produces the position and colour of the four pipe obstacles and feeds
//   the colour mapper directly. Pipes scroll left once per frame, respawn
//   at the right edge with a pseudo-random gap height, and the number of
//   pipes passed by the bird is counted. A three-state game phase
//   (IDLE/RUN/DEAD) freezes the field or reloads it.
//
// Ports
//   Clk                   system clock
//   Reset                 synchronous active-high reset
//   frame_clk             vertical-sync-rate level, asynchronous to Clk
//   start                 start/restart request from game control
//   hit                   collision detected this cycle
//   Pipe1X..Pipe4X        pipe centre column (10 bits)
//   Pipe1Y..Pipe4Y        gap centre row (10 bits)
//   PipekR/G/B            pipe colour, green while alive, grey when dead
//   score                 pipes passed, saturating at 255
//   score_pulse           one-cycle pulse on every scoring event
//   phase                 00 IDLE, 01 RUN, 10 DEAD
module pipe_scroller #(
  parameter int unsigned SPEED     = 2,
  parameter int unsigned SPACING   = 160,
  parameter int unsigned X0        = 400,
  parameter int unsigned BIRD_X    = 160,
  parameter int unsigned GAP_MIN   = 100,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       hit,
  output logic [9:0] Pipe1X,
  output logic [9:0] Pipe2X,
  output logic [9:0] Pipe3X,
  output logic [9:0] Pipe4X,
  output logic [9:0] Pipe1Y,
  output logic [9:0] Pipe2Y,
  output logic [9:0] Pipe3Y,
  output logic [9:0] Pipe4Y,
  output logic [7:0] Pipe1R,
  output logic [7:0] Pipe1G,
  output logic [7:0] Pipe1B,
  output logic [7:0] Pipe2R,
  output logic [7:0] Pipe2G,
  output logic [7:0] Pipe2B,
  output logic [7:0] Pipe3R,
  output logic [7:0] Pipe3G,
  output logic [7:0] Pipe3B,
  output logic [7:0] Pipe4R,
  output logic [7:0] Pipe4G,
  output logic [7:0] Pipe4B,
  output logic [7:0] score,
  output logic       score_pulse,
  output logic [1:0] phase
);

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [10:0] SPEED_W   = 11'(SPEED);
  localparam logic [10:0] RETIRE_X  = 11'(25 + SPEED);
  localparam logic [10:0] WRAP_W    = 11'(4 * SPACING);
  localparam logic [10:0] BIRD_W    = 11'(BIRD_X);
  localparam logic [9:0]  GAP_RESET = 10'd200;

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_RUN  = 2'b01,
    PH_DEAD = 2'b10
  } phase_t;

  phase_t      state_q, state_d;
  logic        step, reload;
  logic        s1, s2, s3, tick;
  logic [15:0] lfsr;
  logic [12:0] lfsr_rev;
  logic [9:0]  gap_a, gap_b;
  logic [9:0]  x_q [4];
  logic [9:0]  y_q [4];
  logic [9:0]  x_d [4];
  logic [9:0]  y_d [4];
  logic [10:0] nx;
  logic        any_cross, draw_taken;
  logic [7:0]  score_q;
  logic        pulse_q;
  logic [7:0]  col_r, col_g, col_b;

  // Gap centre from 13 LFSR bits: GAP_MIN + [6:0] + [12:7], at most 290.
  function automatic logic [9:0] gap_from(input logic [12:0] v);
    return 10'(GAP_MIN) + {3'b000, v[6:0]} + {4'b0000, v[12:7]};
  endfunction

  // One pulse per rising edge of the resynchronised frame strobe.
  assign tick = s2 & ~s3;

  // Low 13 bits of the bit-reversed LFSR, used only when a second pipe
  // respawns on the same tick so the two gaps differ.
  always_comb begin
    lfsr_rev = '0;
    for (int i = 0; i < 13; i++) lfsr_rev[i] = lfsr[15 - i];
  end

  assign gap_a = gap_from(lfsr[12:0]);
  assign gap_b = gap_from(lfsr_rev);

  // Phase register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= PH_IDLE;
    else       state_q <= state_d;
  end

  // Phase transitions. hit outranks both tick and start while running,
  // so a collision on a frame tick never moves the field or scores.
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    reload  = 1'b0;
    case (state_q)
      PH_IDLE: if (start) state_d = PH_RUN;
      PH_RUN: begin
        if (hit)       state_d = PH_DEAD;
        else if (tick) step    = 1'b1;
      end
      PH_DEAD: begin
        if (start) begin
          state_d = PH_IDLE;
          reload  = 1'b1;
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  // Candidate next position for every pipe. A pipe that would drop below
  // column 25 wraps forward by four spacings, which keeps spacing exact and
  // X never below 25. Only an ordinary step can cross the bird column.
  always_comb begin
    nx         = '0;
    any_cross  = 1'b0;
    draw_taken = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nx     = {1'b0, x_q[k]} - SPEED_W;
      y_d[k] = y_q[k];
      if ({1'b0, x_q[k]} < RETIRE_X) begin
        nx         = nx + WRAP_W;
        y_d[k]     = draw_taken ? gap_b : gap_a;
        draw_taken = 1'b1;
      end
      x_d[k] = nx[9:0];
      if (({1'b0, x_q[k]} >= BIRD_W) && (nx < BIRD_W)) any_cross = 1'b1;
    end
  end

  // Frame-strobe synchroniser, LFSR, pipe field, score and colour.
  // The LFSR free-runs in every phase so the gap sequence depends on how
  // long the player waits before starting.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      lfsr    <= SEED;
      score_q <= 8'd0;
      pulse_q <= 1'b0;
      col_r   <= 8'h00;
      col_g   <= 8'hC0;
      col_b   <= 8'h00;
      for (int k = 0; k < 4; k++) begin
        x_q[k] <= 10'(X0 + 32'(k) * SPACING);
        y_q[k] <= GAP_RESET;
      end
    end else begin
      s1      <= frame_clk;
      s2      <= s1;
      s3      <= s2;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      pulse_q <= 1'b0;
      if (state_d == PH_DEAD) begin
        col_r <= 8'h80;
        col_g <= 8'h80;
        col_b <= 8'h80;
      end else begin
        col_r <= 8'h00;
        col_g <= 8'hC0;
        col_b <= 8'h00;
      end
      if (reload) begin
        score_q <= 8'd0;
        for (int k = 0; k < 4; k++) begin
          x_q[k] <= 10'(X0 + 32'(k) * SPACING);
          y_q[k] <= GAP_RESET;
        end
      end else if (step) begin
        for (int k = 0; k < 4; k++) begin
          x_q[k] <= x_d[k];
          y_q[k] <= y_d[k];
        end
        if (any_cross) begin
          pulse_q <= 1'b1;
          if (score_q != 8'hFF) score_q <= score_q + 8'd1;
        end
      end
    end
  end

  assign Pipe1X = x_q[0];
  assign Pipe2X = x_q[1];
  assign Pipe3X = x_q[2];
  assign Pipe4X = x_q[3];
  assign Pipe1Y = y_q[0];
  assign Pipe2Y = y_q[1];
  assign Pipe3Y = y_q[2];
  assign Pipe4Y = y_q[3];
  assign Pipe1R = col_r;
  assign Pipe1G = col_g;
  assign Pipe1B = col_b;
  assign Pipe2R = col_r;
  assign Pipe2G = col_g;
  assign Pipe2B = col_b;
  assign Pipe3R = col_r;
  assign Pipe3G = col_g;
  assign Pipe3B = col_b;
  assign Pipe4R = col_r;
  assign Pipe4G = col_g;
  assign Pipe4B = col_b;
  assign score       = score_q;
  assign score_pulse = pulse_q;
  assign phase       = state_q;

endmodule
